queue_push_arbiter: RTL and testbench
=====================================

Name: queue_push_arbiter

Overview:
Round-robin arbiter that shares the push_back interface of one op-centric queue among p_nreq producers. Each cycle it grants at most one producer and forwards that producer's data and source index to the queue. An optional burst lock lets a winner push up to p_burst consecutive entries before arbitration moves on. It sits directly in front of the queue's push_back port; the pop_front side is untouched.

Parameters:
p_nreq, 4, number of requesters (>=2, need not be a power of two)
p_bitwidth, `TOP_CHANWIDTH, data width per entry
p_burst, 2, max consecutive pushes per grant (>=1; 1 = pure round-robin)
p_idwidth, $clog2(p_nreq), requester index width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (asserted at 0)
req_en  input  [p_nreq]  requester i wants to push this cycle
req_data  input  [p_nreq][p_bitwidth]  per-requester push data
req_rdy  output  [p_nreq]  requester i's push is accepted this cycle
q_push_back_en  output  1  push strobe to queue
q_push_back_rdy  input  1  queue can accept (not full)
q_push_back_data  output  p_bitwidth  muxed data of granted requester
q_push_back_src  output  p_idwidth  index of granted requester
grant_valid  output  1  a requester is granted this cycle
grant_id  output  p_idwidth  granted index (0 when grant_valid=0)

Behaviour:
- Transfer for requester i happens in a cycle iff req_en[i] && req_rdy[i]; at most one req_rdy bit is high.
- Registered state: state {ARB, BURST}, rr_ptr (p_idwidth), owner (p_idwidth), cnt (counts pushes in the current burst, width $clog2(p_burst+1)).
- Reset (rst=0, takes effect immediately, asynchronous): state=ARB, rr_ptr=0, owner=0, cnt=0. All outputs are combinational from state and inputs. While rst=0 they are forced to 0: req_rdy=0, q_push_back_en=0, grant_valid=0, grant_id=0, q_push_back_src=0, q_push_back_data=0.
- Grant logic is combinational, so there is zero-cycle latency from req_en to req_rdy.
  - ARB: grant = first i with req_en[i]=1, scanning rr_ptr, rr_ptr+1, ... with explicit wrap at p_nreq. grant_valid = any req_en.
  - BURST: grant = owner. grant_valid = req_en[owner]. Other requesters are never granted in this state.
- req_rdy[grant] = grant_valid && q_push_back_rdy. fire = that value. q_push_back_en = fire.
- q_push_back_data and q_push_back_src equal the granted requester's data and index whenever grant_valid=1, and are 0 otherwise.
- Next-state rules:
  - ARB, fire, p_burst=1: rr_ptr = grant+1 (mod p_nreq); stay in ARB.
  - ARB, fire, p_burst>1: owner=grant, cnt=1, go to BURST.
  - ARB, no fire: state unchanged. This covers queue full with requests pending; rr_ptr does not move.
  - BURST, fire, cnt+1==p_burst: go to ARB, rr_ptr=owner+1, cnt=0.
  - BURST, fire, cnt+1<p_burst: cnt++.
  - BURST, req_en[owner]=0: burst ends. There is no transfer that cycle; next state ARB, rr_ptr=owner+1, cnt=0. The drop cycle is a dead cycle for the other requesters.
  - BURST, req_en[owner]=1 and q_push_back_rdy=0: hold all state. There is no timeout.
- Re-arbitration costs no extra cycle. In the cycle after a burst ends, the ARB grant is immediate.
- Queue full never changes grant order, only stalls it.
- Fairness: with all requesters continuously active and the queue always ready, every requester receives exactly p_burst pushes per round of p_nreq*p_burst cycles.

Test Plan:
- Reset: drive rst=0 mid-cycle with req_en=4'b1111 → all outputs 0 immediately. After rst=1, requester 0 is granted first (rr_ptr=0).
- Full contention: p_nreq=4, p_burst=2, req_en=1111, q_rdy=1, data=0x10+i → q_push_back_src sequence 0,0,1,1,2,2,3,3,0; data matches 0x10+src.
- Lone requester: only req_en[2]=1 → pushes every cycle with no gaps across burst boundaries; src=2 throughout.
- Queue stall mid-burst: owner 1 pushes once, then q_rdy=0 for 3 cycles with all req_en=1 → no req_rdy high and state held. When q_rdy returns, owner 1 pushes its second entry, then requester 2 is granted.
- Owner drop: owner 3 pushes once, then req_en[3]=0 with req_en[0]=req_en[1]=1 → that cycle has no push. Next cycle requester 0 is granted (wrap from 3+1).
- p_burst=1 build, req_en=0101 → grants alternate 0,2,0,2. Async reset during this build's operation → rr_ptr returns to 0.

Source files
------------

// File: rtl/queue_push_arbiter_if.sv
// ============================================================================
// Module      : queue_push_arbiter_if
// Description : Bundle of producer request lines and the queue push_back port
//               shared by queue_push_arbiter and whoever drives it.
//   req_en/req_data/req_rdy      : per-producer push handshake
//   q_push_back_en/_rdy/_data/_src : push port toward the queue
//   grant_valid/grant_id         : arbitration result for observation
//   modport slave  : arbiter view
//   modport master : producer/queue-side view
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface queue_push_arbiter_if #(
  parameter int p_nreq     = 4,
  parameter int p_bitwidth = 8,
  parameter int p_idwidth  = $clog2(p_nreq)
);
  logic [p_nreq-1:0]                 req_en;
  logic [p_nreq-1:0][p_bitwidth-1:0] req_data;
  logic [p_nreq-1:0]                 req_rdy;
  logic                              q_push_back_en;
  logic                              q_push_back_rdy;
  logic [p_bitwidth-1:0]             q_push_back_data;
  logic [p_idwidth-1:0]              q_push_back_src;
  logic                              grant_valid;
  logic [p_idwidth-1:0]              grant_id;

  modport slave (
    input  req_en, req_data, q_push_back_rdy,
    output req_rdy, q_push_back_en, q_push_back_data, q_push_back_src,
           grant_valid, grant_id
  );

  modport master (
    output req_en, req_data, q_push_back_rdy,
    input  req_rdy, q_push_back_en, q_push_back_data, q_push_back_src,
           grant_valid, grant_id
  );
endinterface

`default_nettype wire

// File: rtl/queue_push_arbiter.sv
// ============================================================================
// Module      : queue_push_arbiter
// Description : Round-robin arbiter sharing one queue push_back port among
//               p_nreq producers, with an optional burst lock of up to
//               p_burst consecutive pushes per winner.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : queue_push_arbiter_if.slave (requests in, push port out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef TOP_CHANWIDTH
`define TOP_CHANWIDTH 32
`endif

module queue_push_arbiter #(
  parameter int p_nreq     = 4,
  parameter int p_bitwidth = `TOP_CHANWIDTH,
  parameter int p_burst    = 2,
  parameter int p_idwidth  = $clog2(p_nreq)
) (
  input  logic                  clk,
  input  logic                  rst,
  queue_push_arbiter_if.slave   bus
);

  localparam int c_cnt_w = $clog2(p_burst + 1);
  localparam int c_ext_w = p_idwidth + 1;
  localparam logic [p_idwidth-1:0] c_last     = p_idwidth'(p_nreq - 1);
  localparam logic [c_ext_w-1:0]   c_nreq_ext = c_ext_w'(p_nreq);
  localparam logic [c_cnt_w-1:0]   c_burst    = c_cnt_w'(p_burst);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [p_idwidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [p_idwidth-1:0] owner_q, owner_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;

  logic [p_idwidth-1:0] grant;
  logic                 grant_found;
  logic                 grant_ok;
  logic                 fire;
  logic [c_ext_w-1:0]   scan_idx;

  // Modulo-p_nreq increment; p_nreq need not be a power of two.
  function automatic logic [p_idwidth-1:0] inc_idx(input logic [p_idwidth-1:0] i);
    return (i == c_last) ? '0 : i + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_ARB;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    grant       = '0;
    grant_found = 1'b0;
    scan_idx    = '0;

    if (state_q == ST_ARB) begin
      // Scan from rr_ptr upward with explicit wrap; first hit wins.
      for (int k = 0; k < p_nreq; k++) begin
        scan_idx = {1'b0, rr_ptr_q} + c_ext_w'(k);
        if (scan_idx >= c_nreq_ext) scan_idx = scan_idx - c_nreq_ext;
        if (!grant_found && bus.req_en[scan_idx[p_idwidth-1:0]]) begin
          grant_found = 1'b1;
          grant       = scan_idx[p_idwidth-1:0];
        end
      end
    end else begin
      grant       = owner_q;
      grant_found = bus.req_en[owner_q];
    end

    // Everything visible is held at zero while reset is asserted.
    grant_ok = rst && grant_found;
    fire     = grant_ok && bus.q_push_back_rdy;

    case (state_q)
      ST_ARB: begin
        if (fire) begin
          if (p_burst == 1) begin
            rr_ptr_d = inc_idx(grant);
          end else begin
            owner_d = grant;
            cnt_d   = c_cnt_w'(1);
            state_d = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (!bus.req_en[owner_q]) begin
          // Owner dropped its request: release without a transfer.
          state_d  = ST_ARB;
          rr_ptr_d = inc_idx(owner_q);
          cnt_d    = '0;
        end else if (fire) begin
          if (cnt_q + c_cnt_w'(1) == c_burst) begin
            state_d  = ST_ARB;
            rr_ptr_d = inc_idx(owner_q);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + c_cnt_w'(1);
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    bus.req_rdy = '0;
    if (fire) bus.req_rdy[grant] = 1'b1;
    bus.q_push_back_en   = fire;
    bus.grant_valid      = grant_ok;
    bus.grant_id         = grant_ok ? grant : '0;
    bus.q_push_back_src  = grant_ok ? grant : '0;
    bus.q_push_back_data = grant_ok ? bus.req_data[grant] : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_queue_push_arbiter.sv
// ============================================================================
// Module      : tb_queue_push_arbiter
// Description : Directed testbench for queue_push_arbiter. Instance u_a uses
//               p_burst=2, instance u_b uses p_burst=1; both have 4
//               requesters and 8-bit data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_queue_push_arbiter;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  queue_push_arbiter_if #(.p_nreq(4), .p_bitwidth(8)) ia ();
  queue_push_arbiter_if #(.p_nreq(4), .p_bitwidth(8)) ib ();

  queue_push_arbiter #(.p_nreq(4), .p_bitwidth(8), .p_burst(2)) u_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ia)
  );

  queue_push_arbiter #(.p_nreq(4), .p_bitwidth(8), .p_burst(1)) u_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ib)
  );

  task automatic reset_a();
    rst_a = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1;
  endtask

  task automatic reset_b();
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    ia.req_en = 4'b1111;
    ia.q_push_back_rdy = 1'b1;
    reset_a();
    repeat (3) begin @(posedge clk); #1; end
    // Assert reset between clock edges; outputs must drop at once.
    @(negedge clk); #1;
    rst_a = 1'b0;
    #1;
    n_checks++; if (ia.req_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset req_rdy: got %b expected 0000", ia.req_rdy); end
    n_checks++; if (ia.q_push_back_en !== 1'b0) begin n_fail++; $display("FAIL reset push_en: got %b expected 0", ia.q_push_back_en); end
    n_checks++; if (ia.grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset grant_valid: got %b expected 0", ia.grant_valid); end
    n_checks++; if (ia.grant_id !== 2'd0) begin n_fail++; $display("FAIL reset grant_id: got %0d expected 0", ia.grant_id); end
    n_checks++; if (ia.q_push_back_src !== 2'd0) begin n_fail++; $display("FAIL reset src: got %0d expected 0", ia.q_push_back_src); end
    n_checks++; if (ia.q_push_back_data !== 8'h00) begin n_fail++; $display("FAIL reset data: got %h expected 00", ia.q_push_back_data); end
    #1;
    rst_a = 1'b1;
    #1;
    n_checks++; if (ia.grant_id !== 2'd0 || ia.grant_valid !== 1'b1) begin n_fail++; $display("FAIL reset first grant: got valid %b id %0d expected valid 1 id 0", ia.grant_valid, ia.grant_id); end
    @(posedge clk); #1;
    ia.req_en = 4'b0000;
  endtask

  task automatic test_full_contention();
    int exp_src[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    reset_a();
    ia.req_en = 4'b1111;
    ia.q_push_back_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_checks++; if (ia.q_push_back_src !== 2'(exp_src[i])) begin n_fail++; $display("FAIL contention src cyc %0d: got %0d expected %0d", i, ia.q_push_back_src, exp_src[i]); end
      n_checks++; if (ia.q_push_back_data !== 8'(8'h10 + exp_src[i])) begin n_fail++; $display("FAIL contention data cyc %0d: got %h expected %h", i, ia.q_push_back_data, 8'(8'h10 + exp_src[i])); end
      n_checks++; if (ia.req_rdy !== 4'(1 << exp_src[i]) || ia.q_push_back_en !== 1'b1) begin n_fail++; $display("FAIL contention rdy cyc %0d: got rdy %b en %b expected rdy %b en 1", i, ia.req_rdy, ia.q_push_back_en, 4'(1 << exp_src[i])); end
      @(posedge clk); #1;
    end
    ia.req_en = 4'b0000;
  endtask

  task automatic test_lone_requester();
    reset_a();
    ia.req_en = 4'b0100;
    ia.q_push_back_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++; if ({ia.q_push_back_en, ia.q_push_back_src} !== 3'b110) begin n_fail++; $display("FAIL lone cyc %0d: got en %b src %0d expected en 1 src 2", i, ia.q_push_back_en, ia.q_push_back_src); end
      @(posedge clk); #1;
    end
    ia.req_en = 4'b0000;
  endtask

  task automatic test_stall_mid_burst();
    reset_a();
    ia.req_en = 4'b0010;
    ia.q_push_back_rdy = 1'b1;
    @(negedge clk);
    n_checks++; if (ia.q_push_back_src !== 2'd1 || ia.q_push_back_en !== 1'b1) begin n_fail++; $display("FAIL stall first push: got en %b src %0d expected en 1 src 1", ia.q_push_back_en, ia.q_push_back_src); end
    @(posedge clk); #1;
    ia.req_en = 4'b1111;
    ia.q_push_back_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (ia.req_rdy !== 4'b0000 || ia.q_push_back_en !== 1'b0) begin n_fail++; $display("FAIL stall hold cyc %0d: got rdy %b en %b expected rdy 0000 en 0", i, ia.req_rdy, ia.q_push_back_en); end
      n_checks++; if (ia.grant_id !== 2'd1) begin n_fail++; $display("FAIL stall owner cyc %0d: got %0d expected 1", i, ia.grant_id); end
      @(posedge clk); #1;
    end
    ia.q_push_back_rdy = 1'b1;
    @(negedge clk);
    n_checks++; if (ia.req_rdy !== 4'b0010 || ia.q_push_back_src !== 2'd1) begin n_fail++; $display("FAIL stall resume: got rdy %b src %0d expected rdy 0010 src 1", ia.req_rdy, ia.q_push_back_src); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (ia.req_rdy !== 4'b0100 || ia.q_push_back_src !== 2'd2) begin n_fail++; $display("FAIL stall next: got rdy %b src %0d expected rdy 0100 src 2", ia.req_rdy, ia.q_push_back_src); end
    @(posedge clk); #1;
    ia.req_en = 4'b0000;
  endtask

  task automatic test_owner_drop();
    reset_a();
    ia.req_en = 4'b1000;
    ia.q_push_back_rdy = 1'b1;
    @(negedge clk);
    n_checks++; if (ia.q_push_back_src !== 2'd3 || ia.q_push_back_en !== 1'b1) begin n_fail++; $display("FAIL drop first push: got en %b src %0d expected en 1 src 3", ia.q_push_back_en, ia.q_push_back_src); end
    @(posedge clk); #1;
    ia.req_en = 4'b0011;
    @(negedge clk);
    n_checks++; if (ia.q_push_back_en !== 1'b0 || ia.req_rdy !== 4'b0000 || ia.grant_valid !== 1'b0) begin n_fail++; $display("FAIL drop dead cycle: got en %b rdy %b gv %b expected en 0 rdy 0000 gv 0", ia.q_push_back_en, ia.req_rdy, ia.grant_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (ia.req_rdy !== 4'b0001 || ia.grant_id !== 2'd0) begin n_fail++; $display("FAIL drop wrap: got rdy %b id %0d expected rdy 0001 id 0", ia.req_rdy, ia.grant_id); end
    @(posedge clk); #1;
    ia.req_en = 4'b0000;
  endtask

  task automatic test_burst_one();
    int exp_id[5] = '{0, 2, 0, 2, 0};
    reset_b();
    ib.req_en = 4'b0101;
    ib.q_push_back_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (ib.grant_id !== 2'(exp_id[i]) || ib.q_push_back_en !== 1'b1) begin n_fail++; $display("FAIL burst1 cyc %0d: got id %0d en %b expected id %0d en 1", i, ib.grant_id, ib.q_push_back_en, exp_id[i]); end
      @(posedge clk); #1;
    end
    // rr_ptr now points past 0, so requester 2 is next in line.
    @(negedge clk);
    n_checks++; if (ib.grant_id !== 2'd2) begin n_fail++; $display("FAIL burst1 pre-reset: got id %0d expected 2", ib.grant_id); end
    #1;
    rst_b = 1'b0;
    #1;
    n_checks++; if (ib.grant_valid !== 1'b0 || ib.req_rdy !== 4'b0000) begin n_fail++; $display("FAIL burst1 in reset: got gv %b rdy %b expected gv 0 rdy 0000", ib.grant_valid, ib.req_rdy); end
    #1;
    rst_b = 1'b1;
    #1;
    n_checks++; if (ib.grant_id !== 2'd0 || ib.grant_valid !== 1'b1) begin n_fail++; $display("FAIL burst1 after reset: got gv %b id %0d expected gv 1 id 0", ib.grant_valid, ib.grant_id); end
    @(posedge clk); #1;
    ib.req_en = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ia.req_en = 4'b0000;
    ia.q_push_back_rdy = 1'b1;
    ib.req_en = 4'b0000;
    ib.q_push_back_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ia.req_data[i] = 8'(8'h10 + i);
      ib.req_data[i] = 8'(8'h20 + i);
    end
    #1;
    test_reset();
    test_full_contention();
    test_lone_requester();
    test_stall_mid_burst();
    test_owner_drop();
    test_burst_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
